gray_decode_arbiter: RTL and testbench

Round-robin arbiter that shares one gray-to-binary decode path among NUM_REQ requesters, e.g. several async-FIFO pointer synchronizers that each need a binary pointer value. Each requester presents a gray-coded word with a valid/ready handshake. One word per cycle is granted, decoded and registered. The output carries the binary value and the requester ID on its own valid/ready handshake.

---
 rtl/gray_arb_pkg.sv | 21 ++
 rtl/gray_decode_comb.sv | 19 +
 rtl/gray_decode_arbiter.sv | 87 ++++++++
 tb/tb_gray_decode_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/gray_arb_pkg.sv
// gray_arb_pkg: helpers shared by the gray-code decoders and encoders.
//   calc_id_w   : requester-ID width for n requesters (minimum 1)
//   gray_to_bin : bit-serial reference decode, intended for bench models
package gray_arb_pkg;

  localparam int MAX_W = 64;

  function automatic int calc_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] gray,
                                                   input int width);
    logic [MAX_W-1:0] b;
    b = '0;
    if (width > 0) b[width-1] = gray[width-1];
    for (int k = width - 2; k >= 0; k--) b[k] = b[k+1] ^ gray[k];
    return b;
  endfunction

endpackage

// File: rtl/gray_decode_comb.sv
// gray_decode_comb: combinational gray-to-binary decode.
//   gray_i : gray-coded word
//   bin_o  : binary value
// A log2-depth XOR-shift tree. After each stage with shift s, every bit
// holds the XOR of itself and the 2s-1 bits above it. The last stage
// therefore leaves each bit as the XOR of all gray bits at or above it.
module gray_decode_comb #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = gray_i;
    for (int s = 1; s < WIDTH; s = s * 2) bin_o = bin_o ^ (bin_o >> s);
  end

endmodule

// File: rtl/gray_decode_arbiter.sv
// gray_decode_arbiter: round-robin arbitration of NUM_REQ gray-coded
// requesters onto one shared decoder, followed by a registered output.
//   clk, rst              : clock; synchronous active-high reset
//   req_valid_i/ready_o   : per-requester handshake (ready is one-hot or zero)
//   req_data_i            : gray words, requester i at [i*WIDTH +: WIDTH]
//   out_valid_o/ready_i   : result handshake
//   out_data_o            : binary decode of the granted word
//   out_id_o              : index of the requester that supplied out_data_o
module gray_decode_arbiter
  import gray_arb_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [ID_W-1:0]          out_id_o
);

  logic [ID_W-1:0]      ptr_q, ptr_d, gnt_idx, off;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W:0]        sum;
  logic                 any_vld, accept_en, xfer;
  logic [WIDTH-1:0]     gnt_gray, gnt_bin;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [ID_W-1:0]      out_id_q;

  // Rotate the requests so ptr lands on bit 0, find the lowest set bit, then
  // add ptr back modulo NUM_REQ. Doubling the vector makes the rotate a plain
  // shift, which works for any NUM_REQ, not only powers of two.
  always_comb begin
    dbl = {req_valid_i, req_valid_i} >> ptr_q;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = ID_W'(k);
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
    gnt_idx = sum[ID_W-1:0];
  end

  assign any_vld   = |req_valid_i;
  assign accept_en = !out_valid_q || out_ready_i;
  assign xfer      = !rst && accept_en && any_vld;

  always_comb begin
    req_ready_o = '0;
    if (xfer) req_ready_o[gnt_idx] = 1'b1;
  end

  assign gnt_gray = req_data_i[int'(gnt_idx)*WIDTH +: WIDTH];
  assign ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  gray_decode_comb #(.WIDTH(WIDTH)) u_dec (
    .gray_i(gnt_gray),
    .bin_o (gnt_bin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt_bin;
      out_id_q    <= gnt_idx;
      ptr_q       <= ptr_d;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;  // drain with nothing to replace it; data/id hold
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// tb_gray_decode_arbiter: directed stimulus with a scoreboard queue. The
// stimulus pushes hand-computed expected words. A monitor pops and compares
// them on every output handshake.
module tb_gray_decode_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;

  always #5 clk = ~clk;

  gray_decode_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_data_i (req_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_id_o   (out_id)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: one word is consumed for each cycle with out_valid && out_ready.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got id %0d data %h want no word", out_id, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_id", 32'(out_id), 32'(mon_e.id));
        chk("out_data", 32'(out_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Drive one cycle and check req_ready. A nonzero rdy also pushes the
  // expected word for the requester that rdy names.
  task automatic cyc(input logic [N-1:0] v, input logic ord, input logic [N*W-1:0] dat,
                     input logic [N-1:0] rdy, input logic [W-1:0] exp_d);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = v;
    out_ready = ord;
    req_data  = dat;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(rdy));
    if (rdy != '0) begin
      e.data = exp_d;
      e.id   = '0;
      for (int k = 0; k < N; k++) if (rdy[k]) e.id = IW'(k);
      sb.push_back(e);
    end
  endtask

  // Byte order in each concatenation is req3, req2, req1, req0.
  localparam logic [N*W-1:0] D1 = {8'hC0, 8'h80, 8'h0B, 8'h01};
  localparam logic [N*W-1:0] D2 = {8'h00, 8'h80, 8'h0B, 8'h01};

  initial begin
    // Reset state. req_ready must stay low while rst is high.
    rst = 1'b1; req_valid = '1; out_ready = 1'b1; req_data = D1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_id", 32'(out_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0; req_valid = '0;

    // Single requester 1, gray 0B -> 0D. Then requester 3 alone (C0 -> 80), ptr -> 0.
    cyc(4'b0010, 1'b1, D1, 4'b0010, 8'h0D);
    cyc(4'b1000, 1'b1, D1, 4'b1000, 8'h80);

    // All valid: 0,1,2,3,0,1 with boundary words 01, 0B, 80, 00.
    cyc(4'b1111, 1'b1, D2, 4'b0001, 8'h01);
    cyc(4'b1111, 1'b1, D2, 4'b0010, 8'h0D);
    cyc(4'b1111, 1'b1, D2, 4'b0100, 8'hFF);
    cyc(4'b1111, 1'b1, D2, 4'b1000, 8'h00);
    cyc(4'b1111, 1'b1, D2, 4'b0001, 8'h01);
    cyc(4'b1111, 1'b1, D2, 4'b0010, 8'h0D);

    // Backpressure holding 0D from requester 1.
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, 1'b0, D2, 4'b0000, 8'h00);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'h0D);
      chk("bp_id", 32'(out_id), 1);
    end
    cyc(4'b1111, 1'b1, D2, 4'b0100, 8'hFF);   // resumes at ptr=2

    // Pointer wrap/skip: ptr 3 -> grant 1 (ptr=2), then 3, then 0, then ptr=1.
    cyc(4'b0010, 1'b1, D2, 4'b0010, 8'h0D);
    cyc(4'b1001, 1'b1, D2, 4'b1000, 8'h00);
    cyc(4'b1001, 1'b1, D2, 4'b0001, 8'h01);
    cyc(4'b1111, 1'b1, D2, 4'b0010, 8'h0D);

    // Idle cycle drains the output. ptr stays 2 and data/id hold.
    cyc(4'b0000, 1'b1, D2, 4'b0000, 8'h00);
    cyc(4'b1111, 1'b1, D2, 4'b0100, 8'hFF);
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_data", 32'(out_data), 32'h0D);
    chk("drain_id", 32'(out_id), 1);

    // Reset while FF from requester 2 is pending: that word is discarded.
    @(posedge clk);
    #1;
    rst = 1'b1; req_valid = '1; out_ready = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 0);
    chk("midrst_pending", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    rst = 1'b0; sb.delete(); req_valid = '1; out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_valid", 32'(out_valid), 0);
    chk("postrst_data", 32'(out_data), 0);
    chk("postrst_ready", 32'(req_ready), 32'b0001);
    sb.push_back('{id: 2'd0, data: 8'h01});

    // Drain whatever is left, with a bounded wait.
    @(posedge clk);
    #1;
    req_valid = '0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
